cmos_cam_gen: RTL and testbench

Parametrised camera/video-timing source for the image-processing simulation benches: next generation of the fixed 800x480 camera emulator. It generates vsync/hsync/href timing and, for each active pixel, the byte offset of that pixel inside a BMP image array. Beyond the previous generation it adds:
- configurable bytes-per-pixel, BMP row padding and bottom-up row order;
- start/stop control at frame boundaries;
- frame pulses and a frame counter.

---
 rtl/cmos_cam_gen_pkg.sv | 42 ++++
 rtl/cmos_cam_gen_if.sv | 30 +++
 rtl/cmos_index_calc.sv | 29 ++
 rtl/cmos_cam_gen.sv | 177 +++++++++++++++++
 tb/tb_cmos_cam_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmos_cam_gen_pkg.sv
// Shared constants, state encoding and timing helpers for the camera timing source.
package cmos_cam_pkg;

  localparam int unsigned DEF_H_ACTIVE  = 800;
  localparam int unsigned DEF_H_FP      = 40;
  localparam int unsigned DEF_H_SYNC    = 128;
  localparam int unsigned DEF_H_BP      = 88;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_V_FP      = 1;
  localparam int unsigned DEF_V_SYNC    = 3;
  localparam int unsigned DEF_V_BP      = 21;
  localparam bit          DEF_HS_POL    = 1'b0;
  localparam bit          DEF_VS_POL    = 1'b0;
  localparam int unsigned DEF_BPP       = 3;
  localparam int unsigned DEF_HDR_BYTES = 54;
  localparam int unsigned DEF_BOTTOM_UP = 1;
  localparam int unsigned DEF_CNT_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } cam_state_e;

  // Clocks per line including blanking.
  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return sync + bp + active + fp;
  endfunction

  // Lines per frame including blanking.
  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return sync + bp + active + fp;
  endfunction

  // BMP row length in bytes, padded up to a multiple of 4.
  function automatic int unsigned bmp_stride(input int unsigned h_active, input int unsigned bpp);
    return (h_active * bpp + 32'd3) & ~32'd3;
  endfunction

endpackage

// File: rtl/cmos_cam_gen_if.sv
// Camera timing bus: run request in, sync/pixel qualifiers and frame events out.
interface cmos_cam_gen_if #(
  parameter int unsigned CNT_W = 12
);
  logic             en;
  logic             cmos_vsync;
  logic             cmos_hsync;
  logic             cmos_href;
  logic [CNT_W-1:0] cmos_x;
  logic [CNT_W-1:0] cmos_y;
  logic [31:0]      cmos_index;
  logic             frame_start;
  logic             frame_end;
  logic [15:0]      frame_cnt;
  logic             running;

  // Timing generator side.
  modport master (
    input  en,
    output cmos_vsync, cmos_hsync, cmos_href, cmos_x, cmos_y, cmos_index,
    output frame_start, frame_end, frame_cnt, running
  );

  // Consumer side.
  modport slave (
    output en,
    input  cmos_vsync, cmos_hsync, cmos_href, cmos_x, cmos_y, cmos_index,
    input  frame_start, frame_end, frame_cnt, running
  );
endinterface

// File: rtl/cmos_index_calc.sv
// Combinational byte offset of pixel (x, y) inside a BMP image array.
module cmos_index_calc
  import cmos_cam_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned BPP       = DEF_BPP,
  parameter int unsigned STRIDE    = bmp_stride(DEF_H_ACTIVE, DEF_BPP),
  parameter int unsigned HDR_BYTES = DEF_HDR_BYTES,
  parameter int unsigned BOTTOM_UP = DEF_BOTTOM_UP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE
) (
  input  logic [CNT_W-1:0] x_i,
  input  logic [CNT_W-1:0] y_i,
  input  logic             active_i,
  output logic [31:0]      index_c
);

  logic [31:0] row_c;

  // Bottom-up BMPs store image row 0 last; offset is zero outside the active window.
  always_comb begin
    row_c   = (BOTTOM_UP != 0) ? (32'(V_ACTIVE - 1) - 32'(y_i)) : 32'(y_i);
    index_c = '0;
    if (active_i) begin
      index_c = 32'(HDR_BYTES) + row_c * 32'(STRIDE) + 32'(x_i) * 32'(BPP);
    end
  end

endmodule

// File: rtl/cmos_cam_gen.sv
// Parametrised camera timing source: counters, run/stop FSM and registered outputs.
module cmos_cam_gen
  import cmos_cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HS_POL    = DEF_HS_POL,
  parameter bit          VS_POL    = DEF_VS_POL,
  parameter int unsigned BPP       = DEF_BPP,
  parameter int unsigned HDR_BYTES = DEF_HDR_BYTES,
  parameter int unsigned BOTTOM_UP = DEF_BOTTOM_UP,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst_n,
  cmos_cam_gen_if.master cam
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned STRIDE  = bmp_stride(H_ACTIVE, BPP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);

  cam_state_e       state_q;
  logic             running_q;
  logic [CNT_W-1:0] hcnt_q, vcnt_q;
  logic [CNT_W-1:0] hcnt_d, vcnt_d;
  logic             line_last_c, frame_last_c;

  logic             run_c, vs_c, hs_c, act_c, fs_c, fe_c;
  logic [CNT_W-1:0] x_c, y_c;
  logic [31:0]      index_c;

  logic             vsync_q, hsync_q, href_q, fs_q, fe_q;
  logic [CNT_W-1:0] x_q, y_q;
  logic [31:0]      index_q;
  logic [15:0]      fcnt_q;

  // Free-running raster position while the generator is active.
  always_comb begin
    line_last_c  = (hcnt_q == H_LAST);
    frame_last_c = line_last_c && (vcnt_q == V_LAST);
    hcnt_d       = line_last_c ? '0 : hcnt_q + CNT_W'(1);
    vcnt_d       = vcnt_q;
    if (line_last_c) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
    end
  end

  // Run/stop FSM with counters; stop and restart only take effect at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hcnt_q <= '0;
          vcnt_q <= '0;
          if (cam.en) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          hcnt_q <= hcnt_d;
          vcnt_q <= vcnt_d;
          if (!cam.en) begin
            state_q <= ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          hcnt_q <= hcnt_d;
          vcnt_q <= vcnt_d;
          if (frame_last_c) begin
            if (cam.en) begin
              state_q <= ST_RUN;
            end else begin
              state_q   <= ST_IDLE;
              running_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          hcnt_q    <= '0;
          vcnt_q    <= '0;
        end
      endcase
    end
  end

  // Raster decode; everything reads as inactive while idle.
  always_comb begin
    run_c = (state_q != ST_IDLE);
    vs_c  = run_c && (vcnt_q < VS_END);
    hs_c  = run_c && (hcnt_q < HS_END);
    act_c = run_c && (vcnt_q >= VA_START) && (vcnt_q < VA_END) &&
            (hcnt_q >= HA_START) && (hcnt_q < HA_END);
    x_c   = act_c ? (hcnt_q - HA_START) : '0;
    y_c   = act_c ? (vcnt_q - VA_START) : '0;
    fs_c  = run_c && (hcnt_q == '0) && (vcnt_q == '0);
    fe_c  = act_c && (x_c == X_LAST) && (y_c == Y_LAST);
  end

  cmos_index_calc #(
    .CNT_W     (CNT_W),
    .BPP       (BPP),
    .STRIDE    (STRIDE),
    .HDR_BYTES (HDR_BYTES),
    .BOTTOM_UP (BOTTOM_UP),
    .V_ACTIVE  (V_ACTIVE)
  ) u_index_calc (
    .x_i      (x_c),
    .y_i      (y_c),
    .active_i (act_c),
    .index_c  (index_c)
  );

  // Output registers: one clock behind the raster position, all in the same stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= ~VS_POL;
      hsync_q <= ~HS_POL;
      href_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      index_q <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      vsync_q <= vs_c ? VS_POL : ~VS_POL;
      hsync_q <= hs_c ? HS_POL : ~HS_POL;
      href_q  <= act_c;
      x_q     <= x_c;
      y_q     <= y_c;
      index_q <= index_c;
      fs_q    <= fs_c;
      fe_q    <= fe_c;
      if (fe_c) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
    end
  end

  assign cam.cmos_vsync  = vsync_q;
  assign cam.cmos_hsync  = hsync_q;
  assign cam.cmos_href   = href_q;
  assign cam.cmos_x      = x_q;
  assign cam.cmos_y      = y_q;
  assign cam.cmos_index  = index_q;
  assign cam.frame_start = fs_q;
  assign cam.frame_end   = fe_q;
  assign cam.frame_cnt   = fcnt_q;
  assign cam.running     = running_q;

endmodule

// File: tb/tb_cmos_cam_gen.sv
// Directed bench for cmos_cam_gen on a 9x6 frame, bottom-up and top-down index variants.
module tb_cmos_cam_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   cyc;
  int   errors;
  int   checks;

  always #5 clk = ~clk;

  cmos_cam_gen_if #(.CNT_W(12)) cam_bu ();
  cmos_cam_gen_if #(.CNT_W(12)) cam_td ();

  assign cam_bu.en = en;
  assign cam_td.en = en;

  cmos_cam_gen #(
    .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BPP(3), .HDR_BYTES(54),
    .BOTTOM_UP(1), .CNT_W(12)
  ) dut_bu (
    .clk   (clk),
    .rst_n (rst_n),
    .cam   (cam_bu)
  );

  cmos_cam_gen #(
    .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BPP(3), .HDR_BYTES(54),
    .BOTTOM_UP(0), .CNT_W(12)
  ) dut_td (
    .clk   (clk),
    .rst_n (rst_n),
    .cam   (cam_td)
  );

  // Expected output levels after the edge that registers raster cycle c (hsync/vsync active low).
  typedef struct {
    int c;
    int hs;
    int vs;
    int href;
    int x;
    int y;
    int idx_bu;
    int idx_td;
    int fs;
    int fe;
    int fc;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vsync"},   32'(cam_bu.cmos_vsync), 1);
    chk({tag, "_hsync"},   32'(cam_bu.cmos_hsync), 1);
    chk({tag, "_href"},    32'(cam_bu.cmos_href), 0);
    chk({tag, "_x"},       32'(cam_bu.cmos_x), 0);
    chk({tag, "_y"},       32'(cam_bu.cmos_y), 0);
    chk({tag, "_index"},   cam_bu.cmos_index, 0);
    chk({tag, "_fs"},      32'(cam_bu.frame_start), 0);
    chk({tag, "_fe"},      32'(cam_bu.frame_end), 0);
    chk({tag, "_running"}, 32'(cam_bu.running), 0);
  endtask

  initial begin
    int ti;
    int hs_n, vs_n, hr_n, hr_td_n, fs_seen;

    errors = 0;
    checks = 0;
    cyc    = 0;

    tbl[0]  = '{0,  0, 0, 0, 0, 0,  0,  0, 1, 0, 0};
    tbl[1]  = '{1,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[2]  = '{2,  1, 0, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[3]  = '{8,  1, 0, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[4]  = '{9,  0, 1, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[5]  = '{12, 1, 1, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[6]  = '{21, 1, 1, 1, 0, 0, 86, 54, 0, 0, 0};
    tbl[7]  = '{22, 1, 1, 1, 1, 0, 89, 57, 0, 0, 0};
    tbl[8]  = '{25, 1, 1, 1, 4, 0, 98, 66, 0, 0, 0};
    tbl[9]  = '{26, 1, 1, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[10] = '{27, 0, 1, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[11] = '{30, 1, 1, 1, 0, 1, 70, 70, 0, 0, 0};
    tbl[12] = '{42, 1, 1, 1, 3, 2, 63, 95, 0, 0, 0};
    tbl[13] = '{43, 1, 1, 1, 4, 2, 66, 98, 0, 1, 1};
    tbl[14] = '{44, 1, 1, 0, 0, 0,  0,  0, 0, 0, 1};
    tbl[15] = '{48, 1, 1, 0, 0, 0,  0,  0, 0, 0, 1};
    tbl[16] = '{53, 1, 1, 0, 0, 0,  0,  0, 0, 0, 1};
    tbl[17] = '{54, 0, 0, 0, 0, 0,  0,  0, 1, 0, 1};

    // Reset values, then idle with en low.
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_fcnt", 32'(cam_bu.frame_cnt), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("idle");

    // Start: frame_start appears one cycle after en is sampled.
    en  = 1'b1;
    cyc = -2;
    tick();
    chk("start_fs_early", 32'(cam_bu.frame_start), 0);
    chk("start_running", 32'(cam_bu.running), 1);

    ti = 0; hs_n = 0; vs_n = 0; hr_n = 0; hr_td_n = 0;
    for (int k = 0; k <= 54; k++) begin
      tick();
      if (k < 54) begin
        if (cam_bu.cmos_hsync == 1'b0) hs_n++;
        if (cam_bu.cmos_vsync == 1'b0) vs_n++;
        if (cam_bu.cmos_href)          hr_n++;
        if (cam_td.cmos_href)          hr_td_n++;
      end
      if (ti < NV && tbl[ti].c == cyc) begin
        chk("tbl_hsync", 32'(cam_bu.cmos_hsync), tbl[ti].hs);
        chk("tbl_vsync", 32'(cam_bu.cmos_vsync), tbl[ti].vs);
        chk("tbl_href",  32'(cam_bu.cmos_href), tbl[ti].href);
        chk("tbl_x",     32'(cam_bu.cmos_x), tbl[ti].x);
        chk("tbl_y",     32'(cam_bu.cmos_y), tbl[ti].y);
        chk("tbl_idx_bu", cam_bu.cmos_index, tbl[ti].idx_bu);
        chk("tbl_idx_td", cam_td.cmos_index, tbl[ti].idx_td);
        chk("tbl_href_td", 32'(cam_td.cmos_href), tbl[ti].href);
        chk("tbl_fs",    32'(cam_bu.frame_start), tbl[ti].fs);
        chk("tbl_fe",    32'(cam_bu.frame_end), tbl[ti].fe);
        chk("tbl_fcnt",  32'(cam_bu.frame_cnt), tbl[ti].fc);
        chk("tbl_running", 32'(cam_bu.running), 1);
        ti++;
      end
    end
    chk("hsync_cycles_per_frame", hs_n, 12);
    chk("vsync_cycles_per_frame", vs_n, 9);
    chk("href_cycles_bu", hr_n, 15);
    chk("href_cycles_td", hr_td_n, 15);

    // Asynchronous reset in the middle of an active line of frame 2.
    while (cyc < 76) tick();
    chk("pre_rst_href", 32'(cam_bu.cmos_href), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_fcnt", 32'(cam_bu.frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -2;
    tick();
    tick();
    chk("restart_fs", 32'(cam_bu.frame_start), 1);
    chk("restart_hsync", 32'(cam_bu.cmos_hsync), 0);
    chk("restart_vsync", 32'(cam_bu.cmos_vsync), 0);

    // Drop en mid-frame: the frame completes, then the generator idles.
    fs_seen = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (cyc == 21) begin
        chk("restart_href", 32'(cam_bu.cmos_href), 1);
        chk("restart_idx", cam_bu.cmos_index, 86);
      end
      if (cyc == 30) en = 1'b0;
      if (cyc == 43) begin
        chk("stop_fe", 32'(cam_bu.frame_end), 1);
        chk("stop_fcnt", 32'(cam_bu.frame_cnt), 1);
      end
      if (cyc == 52) chk("stop_running_last", 32'(cam_bu.running), 1);
      if (cyc == 53) chk("stop_running_off", 32'(cam_bu.running), 0);
      if (cyc >= 54 && cam_bu.frame_start) fs_seen++;
    end
    chk("idle_no_fs", fs_seen, 0);
    chk_idle("stopped");
    chk("stopped_fcnt", 32'(cam_bu.frame_cnt), 1);

    // Counter wrap, plus en re-asserted on the final cycle of a stopping frame.
    force dut_bu.fcnt_q = 16'hFFFF;
    #1;
    release dut_bu.fcnt_q;
    en  = 1'b1;
    cyc = -2;
    tick();
    for (int k = 0; k <= 75; k++) begin
      tick();
      if (cyc == 10) en = 1'b0;
      if (cyc == 42) begin
        chk("wrap_fcnt_pre", 32'(cam_bu.frame_cnt), 32'hFFFF);
        chk("wrap_fe_pre", 32'(cam_bu.frame_end), 0);
      end
      if (cyc == 43) begin
        chk("wrap_fcnt", 32'(cam_bu.frame_cnt), 0);
        chk("wrap_fe", 32'(cam_bu.frame_end), 1);
      end
      if (cyc == 44) chk("fe_width", 32'(cam_bu.frame_end), 0);
      if (cyc == 52) en = 1'b1;
      if (cyc == 53) chk("rearm_running", 32'(cam_bu.running), 1);
      if (cyc == 54) begin
        chk("rearm_fs", 32'(cam_bu.frame_start), 1);
        chk("rearm_hsync", 32'(cam_bu.cmos_hsync), 0);
      end
      if (cyc == 55) chk("fs_width", 32'(cam_bu.frame_start), 0);
      if (cyc == 75) begin
        chk("rearm_href", 32'(cam_bu.cmos_href), 1);
        chk("rearm_idx", cam_bu.cmos_index, 86);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
